sc_control_sequencer: RTL

- Multi-cycle FSM that sequences the DATAPATH block: fetch, PC increment, decode, execute/load.
- Drives the A/B/C register-address muxes, their MIR/IR select lines, the ALU operation and the RD (memory-to-C-bus) select.
- Handshakes with main memory, whose address is taken from the datapath A bus.
- Holds the processor status register (PSR: N,Z,V,C) latched from the ALU flags.

---
 rtl/sc_control_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sc_control_sequencer.sv
// sc_control_sequencer: multi-cycle fetch/incpc/decode/execute sequencer for the DATAPATH.
// Revision: 1.0
`default_nettype none

module sc_control_sequencer #(
   parameter int DATAWIDTH_MIR_DIRECTION = 6,
   parameter int DATAWIDTH_ALU_SELECTION = 4,
   parameter int DATAWIDTH_DECODEROP     = 8,
   parameter logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_ADD = 4'd0,
   parameter logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_SUB = 4'd1,
   parameter logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_AND = 4'd2,
   parameter logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_OR  = 4'd3,
   parameter logic [DATAWIDTH_MIR_DIRECTION-1:0] REG_PC      = 6'd2,
   parameter logic [DATAWIDTH_MIR_DIRECTION-1:0] REG_IR      = 6'd3,
   parameter logic [DATAWIDTH_MIR_DIRECTION-1:0] REG_ONE     = 6'd1,
   parameter logic [DATAWIDTH_MIR_DIRECTION-1:0] REG_NOWRITE = 6'd0
) (
   input  logic                               SC_CTRL_CLOCK_50,
   input  logic                               SC_CTRL_RESET_InHigh,
   input  logic                               SC_CTRL_Run_In,
   input  logic [DATAWIDTH_DECODEROP-1:0]     SC_CTRL_OPS_InBus,
   input  logic                               SC_CTRL_Bit13_In,
   input  logic                               SC_CTRL_SetCode_In,
   input  logic                               SC_CTRL_FlagNegative_InLow,
   input  logic                               SC_CTRL_FlagZero_InLow,
   input  logic                               SC_CTRL_FlagOverflow_InLow,
   input  logic                               SC_CTRL_FlagCarry_InLow,
   input  logic                               SC_CTRL_MemAck_In,
   output logic                               SC_CTRL_MemReq_Out,
   output logic [DATAWIDTH_MIR_DIRECTION-1:0] SC_CTRL_DirA_OutBus,
   output logic [DATAWIDTH_MIR_DIRECTION-1:0] SC_CTRL_DirB_OutBus,
   output logic [DATAWIDTH_MIR_DIRECTION-1:0] SC_CTRL_DirC_OutBus,
   output logic                               SC_CTRL_SelectA_Out,
   output logic                               SC_CTRL_SelectB_Out,
   output logic                               SC_CTRL_SelectC_Out,
   output logic [DATAWIDTH_ALU_SELECTION-1:0] SC_CTRL_ALUOperation_OutBus,
   output logic                               SC_CTRL_RD_Out,
   output logic [3:0]                         SC_CTRL_PSR_OutBus,
   output logic                               SC_CTRL_Halted_Out,
   output logic                               SC_CTRL_Illegal_Out,
   output logic [2:0]                         SC_CTRL_State_OutBus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_INCPC   = 3'd2,
      S_DECODE  = 3'd3,
      S_EXEC    = 3'd4,
      S_LOAD    = 3'd5,
      S_ILLEGAL = 3'd6
   } state_t;

   state_t     state_q;
   logic [3:0] psr_q;

   logic [1:0] op;
   logic [5:0] op3;
   logic       alu_legal;
   logic       ld_legal;
   logic [DATAWIDTH_ALU_SELECTION-1:0] exec_alu;

   assign op  = SC_CTRL_OPS_InBus[7:6];
   assign op3 = SC_CTRL_OPS_InBus[5:0];

   // op3[4] selects the condition-code variant, so it is don't-care for legality.
   assign alu_legal = (op == 2'b10) && !SC_CTRL_Bit13_In && !op3[5] && !op3[3] &&
                      ((op3[2:0] == 3'b000) || (op3[2:0] == 3'b100) ||
                       (op3[2:0] == 3'b001) || (op3[2:0] == 3'b010));
   assign ld_legal  = (op == 2'b11) && (op3 == 6'b000000) && !SC_CTRL_Bit13_In;

   always_comb begin
      exec_alu = ALU_ADD;
      case (op3[2:0])
         3'b100:  exec_alu = ALU_SUB;
         3'b001:  exec_alu = ALU_AND;
         3'b010:  exec_alu = ALU_OR;
         default: exec_alu = ALU_ADD;
      endcase
   end

   always_ff @(posedge SC_CTRL_CLOCK_50) begin
      if (SC_CTRL_RESET_InHigh) begin
         state_q <= S_IDLE;
         psr_q   <= 4'b0000;
      end else begin
         case (state_q)
            S_IDLE:   if (SC_CTRL_Run_In) state_q <= S_FETCH;
            S_FETCH:  if (SC_CTRL_MemAck_In) state_q <= S_INCPC;
            S_INCPC:  state_q <= S_DECODE;
            S_DECODE: begin
               if (alu_legal)     state_q <= S_EXEC;
               else if (ld_legal) state_q <= S_LOAD;
               else               state_q <= S_ILLEGAL;
            end
            S_EXEC: begin
               if (op3[4] && SC_CTRL_SetCode_In)
                  psr_q <= {~SC_CTRL_FlagNegative_InLow, ~SC_CTRL_FlagZero_InLow,
                            ~SC_CTRL_FlagOverflow_InLow, ~SC_CTRL_FlagCarry_InLow};
               state_q <= SC_CTRL_Run_In ? S_FETCH : S_IDLE;
            end
            S_LOAD:   if (SC_CTRL_MemAck_In) state_q <= SC_CTRL_Run_In ? S_FETCH : S_IDLE;
            S_ILLEGAL: state_q <= S_ILLEGAL;
            default:  state_q <= S_ILLEGAL;
         endcase
      end
   end

   always_comb begin
      SC_CTRL_MemReq_Out          = 1'b0;
      SC_CTRL_DirA_OutBus         = '0;
      SC_CTRL_DirB_OutBus         = '0;
      SC_CTRL_DirC_OutBus         = REG_NOWRITE;
      SC_CTRL_SelectA_Out         = 1'b0;
      SC_CTRL_SelectB_Out         = 1'b0;
      SC_CTRL_SelectC_Out         = 1'b0;
      SC_CTRL_ALUOperation_OutBus = ALU_ADD;
      SC_CTRL_RD_Out              = 1'b0;
      case (state_q)
         S_FETCH: begin
            SC_CTRL_MemReq_Out  = 1'b1;
            SC_CTRL_RD_Out      = 1'b1;
            SC_CTRL_DirA_OutBus = REG_PC;
            if (SC_CTRL_MemAck_In) SC_CTRL_DirC_OutBus = REG_IR;
         end
         S_INCPC: begin
            SC_CTRL_DirA_OutBus = REG_PC;
            SC_CTRL_DirB_OutBus = REG_ONE;
            SC_CTRL_DirC_OutBus = REG_PC;
         end
         S_EXEC: begin
            SC_CTRL_SelectA_Out         = 1'b1;
            SC_CTRL_SelectB_Out         = 1'b1;
            SC_CTRL_SelectC_Out         = 1'b1;
            SC_CTRL_ALUOperation_OutBus = exec_alu;
         end
         S_LOAD: begin
            SC_CTRL_MemReq_Out  = 1'b1;
            SC_CTRL_RD_Out      = 1'b1;
            SC_CTRL_SelectA_Out = 1'b1;
            if (SC_CTRL_MemAck_In) SC_CTRL_SelectC_Out = 1'b1;
         end
         default: ;
      endcase
   end

   assign SC_CTRL_PSR_OutBus   = psr_q;
   assign SC_CTRL_Halted_Out   = (state_q == S_IDLE);
   assign SC_CTRL_Illegal_Out  = (state_q == S_ILLEGAL);
   assign SC_CTRL_State_OutBus = state_q;

endmodule

`default_nettype wire
